bcd2bin: RTL and testbench
==========================

# bcd2bin

Sequential BCD-to-binary converter, the inverse of the calculator's binary-to-BCD display path. It accepts eight packed BCD digits plus a sign flag, for example from keypad or digit-entry logic. It produces a 28-bit two's-complement integer for the arithmetic core. It processes one digit per clock, most significant digit first, using multiply-by-ten-and-add. It takes one operand at a time under a valid/ready handshake.

## Interface
- No parameters. Widths are fixed: 8 digits in, 28-bit signed result out.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valid_in  in  1  operand present on bcd/sign; accepted only when ready=1.
- bcd  in  32  8 BCD digits; digit k is bcd[4k+3:4k], and digit 7 is the most significant.
- sign  in  1  1 = operand is negative.
- ready  out  1  converter idle; high when state is IDLE.
- valid_out  out  1  one-cycle pulse; bin and error are valid while it is high.
- bin  out  28  signed result, held until the next result.
- error  out  1  1 = the accepted operand contained a digit >9; held with bin.

## Operation
- States: IDLE, CONV, DONE.
- IDLE
  - ready=1.
  - On valid_in=1, capture bcd into a digit shift register and capture sign.
  - Clear the accumulator, digit counter and error flag.
  - Go to CONV.
- CONV
  - Each cycle, take the top nibble d of the shift register and set acc = acc*10 + d.
  - Implement *10 as (acc<<3)+(acc<<1). No multiplier.
  - Shift the register left by 4 and increment the 3-bit counter.
  - If d>9, set the sticky error flag.
  - After the 8th digit (counter wraps 7->0), go to DONE.
- DONE
  - Register the result into bin: -acc if sign=1, else acc, as 28-bit two's complement.
  - Register error. If error, force bin to 0.
  - Pulse valid_out for one cycle and return to IDLE.
- Width rules
  - acc is 27 bits unsigned; the maximum, 99,999,999, is below 2^27, so there is no overflow for valid input.
  - The negated value fits 28-bit signed.
  - The sign flag on a zero magnitude gives bin=0; there is no negative zero.
- Invalid digits
  - These still go through the arithmetic, and acc may wrap.
  - The wrapped value is discarded because bin is forced to 0.
- While ready=0, valid_in is ignored. The operand is dropped, not queued. The producer must hold valid_in until it sees ready=1.
- bcd and sign are sampled only on the accepting edge. Changes afterward do not affect the conversion in progress.

## Timing
- Reset values: ready=1, valid_out=0, bin=0, error=0. State=IDLE, and acc, counter and shift register are 0.
- Acceptance: on the rising edge N where ready=1 and valid_in=1.
- Edges N+1..N+8: digits 7..0 processed in CONV.
- Edge N+9: DONE registers bin/error and asserts valid_out. The next edge clears valid_out and returns to IDLE. Latency from acceptance to valid_out high is 9 cycles.
- ready goes low after edge N and high again after edge N+10. The earliest next acceptance is edge N+11, so sustained throughput is one operand per 11 cycles.
- bin and error change only at the DONE edge and otherwise hold their last value.
- Reset asserted mid-conversion immediately forces all reset values and discards the operand. No valid_out is produced for it.
- valid_in held high continuously means a new operand is accepted on every cycle that ready=1.

## Test plan
- After reset release: bcd=32'h00000000, sign=0 -> valid_out exactly 9 cycles after acceptance, bin=28'h0000000, error=0. Also check reset values before the first operand.
- Maximum values: bcd=32'h99999999, sign=0 -> bin=28'h5F5E0FF. Then sign=1 -> bin=28'hA0A1F01. error=0 in both cases.
- Small negative and negative zero: bcd=32'h00001234, sign=1 -> bin=28'hFFFFB2E. Then bcd=32'h00000000, sign=1 -> bin=28'h0000000.
- Invalid digit: bcd=32'h0000A000 -> error=1, bin=0. The next valid operand 32'h00000042 -> error=0, bin=28'h000002A.
- Busy and hold: pulse valid_in with bcd=32'h00000777 three cycles into a conversion of 32'h00000005 -> the pulse is ignored, exactly one valid_out occurs, and bin=5. Between results, bin holds its value and valid_out is never high for two consecutive cycles.
- Reset mid-operation: assert rst at CONV cycle 4 of 32'h12345678 -> outputs go to reset values asynchronously and no valid_out follows. A fresh 32'h12345678 after release -> bin=28'h0BC614E.

Source files
------------

// File: rtl/bcd2bin.sv
// ---------------------------------------------------------------------------
// bcd2bin : sequential BCD-to-binary converter.
//
// Accepts eight packed BCD digits plus a sign flag and produces a 28-bit
// two's-complement integer. One digit is folded in per clock, most
// significant first, as acc = acc*10 + d, with *10 built from two shifts.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   valid_in   in   1   operand present on bcd/sign (taken only when ready)
//   bcd        in  32   digit k = bcd[4k+3:4k], digit 7 most significant
//   sign       in   1   1 = operand is negative
//   ready      out  1   converter idle, operand can be accepted
//   valid_out  out  1   one-cycle pulse, bin/error valid
//   bin        out 28   signed result, held until the next result
//   error      out  1   operand contained a digit > 9 (bin forced to 0)
// ---------------------------------------------------------------------------
module bcd2bin (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] bcd,
  input  logic        sign,
  output logic        ready,
  output logic        valid_out,
  output logic [27:0] bin,
  output logic        error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;

  logic [31:0] shift_r;     // remaining digits, current digit in the top nibble
  logic [26:0] acc_r;       // unsigned magnitude accumulator
  logic [2:0]  cnt_r;       // digits processed so far, wraps 7->0 on the last
  logic        err_r;       // sticky invalid-digit flag for this operand
  logic        sign_r;      // sign captured at acceptance

  logic [3:0]  digit_s;
  logic [26:0] acc_next_s;
  logic [27:0] result_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic. DONE lasts two cycles: the first registers the result
  // and raises valid_out, the second drops valid_out and returns to IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (valid_in) begin
          state_s = CONV;
        end else begin
          state_s = IDLE;
        end
      end
      CONV: begin
        if (cnt_r == 3'd7) begin
          state_s = DONE;
        end else begin
          state_s = CONV;
        end
      end
      DONE: begin
        if (valid_out) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output and datapath combinational terms.
  always_comb begin
    ready      = (state_r == IDLE);
    digit_s    = shift_r[31:28];
    // acc*10 = acc*8 + acc*2; invalid digits may wrap, result is discarded
    acc_next_s = (acc_r << 3) + (acc_r << 1) + {23'd0, digit_s};
    if (err_r) begin
      result_s = 28'd0;
    end else if (sign_r) begin
      // zero magnitude negates to zero, so there is no negative zero
      result_s = 28'd0 - {1'b0, acc_r};
    end else begin
      result_s = {1'b0, acc_r};
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r   <= 32'd0;
      acc_r     <= 27'd0;
      cnt_r     <= 3'd0;
      err_r     <= 1'b0;
      sign_r    <= 1'b0;
      valid_out <= 1'b0;
      bin       <= 28'd0;
      error     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          valid_out <= 1'b0;
          if (valid_in) begin
            shift_r <= bcd;
            sign_r  <= sign;
            acc_r   <= 27'd0;
            cnt_r   <= 3'd0;
            err_r   <= 1'b0;
          end
        end
        CONV: begin
          acc_r   <= acc_next_s;
          shift_r <= {shift_r[27:0], 4'd0};
          cnt_r   <= cnt_r + 3'd1;
          if (digit_s > 4'd9) begin
            err_r <= 1'b1;
          end
        end
        DONE: begin
          if (!valid_out) begin
            bin       <= result_s;
            error     <= err_r;
            valid_out <= 1'b1;
          end else begin
            valid_out <= 1'b0;
          end
        end
        default: begin
          valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin.sv
// ---------------------------------------------------------------------------
// tb_bcd2bin : scoreboard bench for bcd2bin. The driver pushes the expected
// result of every accepted operand; an independent monitor pops and compares
// on each valid_out pulse and also checks latency and output hold behaviour.
// ---------------------------------------------------------------------------
module tb_bcd2bin;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [31:0] bcd;
  logic        sign;
  logic        ready;
  logic        valid_out;
  logic [27:0] bin;
  logic        error;

  typedef struct {
    logic [27:0] bin;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total_checks = 0;
  int   passed_checks = 0;
  int   cyc = 0;
  int   n_pushed = 0;
  int   n_results = 0;

  bcd2bin dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .bcd       (bcd),
    .sign      (sign),
    .ready     (ready),
    .valid_out (valid_out),
    .bin       (bin),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      passed_checks++;
    end
  endtask

  // Reference model: decimal value of the digits, negated if signed,
  // zero if any digit is not a decimal digit.
  function automatic exp_t model(input logic [31:0] b, input logic s);
    exp_t   r;
    longint v = 0;
    bit     e = 0;
    for (int k = 7; k >= 0; k--) begin
      int d;
      d = int'((b >> (4 * k)) & 32'hF);
      if (d > 9) e = 1;
      v = v * 10 + d;
    end
    if (s) v = -v;
    r.err = e;
    r.bin = e ? 28'd0 : v[27:0];
    r.cyc = 0;
    return r;
  endfunction

  // Present an operand until accepted (bounded), then record the expectation.
  task automatic send(input logic [31:0] b, input logic s);
    int   n = 0;
    bit   took = 0;
    exp_t e;
    valid_in = 1'b1;
    bcd      = b;
    sign     = s;
    while (!took && n < 40) begin
      @(negedge clk);
      took = ready;
      @(posedge clk);
      #1;
      n++;
    end
    valid_in = 1'b0;
    bcd      = $urandom;   // later changes must not disturb the conversion
    sign     = 1'($urandom_range(0, 1));
    if (!took) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      e     = model(b, s);
      e.cyc = cyc;
      sb.push_back(e);
      n_pushed++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: pops on each valid_out, checks latency, pulse width and hold.
  logic        prev_valid = 1'b0;
  logic [27:0] prev_bin   = 28'd0;
  logic        prev_err   = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
      prev_bin   = 28'd0;
      prev_err   = 1'b0;
    end else begin
      if (valid_out) begin
        n_results++;
        check("valid_out_single_cycle", {31'd0, prev_valid}, 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_valid_out", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("bin", {4'd0, bin}, {4'd0, e.bin});
          check("error", {31'd0, error}, {31'd0, e.err});
          check("latency", 32'(cyc - e.cyc), 32'd9);
        end
      end else begin
        check("bin_hold", {4'd0, bin}, {4'd0, prev_bin});
        check("error_hold", {31'd0, error}, {31'd0, prev_err});
      end
      prev_valid = valid_out;
      prev_bin   = bin;
      prev_err   = error;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    bcd      = 32'd0;
    sign     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_valid_out", {31'd0, valid_out}, 32'd0);
    check("reset_bin", {4'd0, bin}, 32'd0);
    check("reset_error", {31'd0, error}, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Directed cases
    send(32'h00000000, 1'b0);
    drain();
    send(32'h99999999, 1'b0);
    send(32'h99999999, 1'b1);
    send(32'h00001234, 1'b1);
    send(32'h00000000, 1'b1);
    send(32'h0000A000, 1'b0);
    send(32'h00000042, 1'b0);
    drain();
    check("max_pos_model", {4'd0, model(32'h99999999, 1'b0).bin}, 32'h05F5E0FF);

    // Busy pulse ignored while converting
    send(32'h00000005, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    valid_in = 1'b1;
    bcd      = 32'h00000777;
    sign     = 1'b0;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    drain();
    repeat (5) @(posedge clk);
    #1;
    check("busy_bin", {4'd0, bin}, 32'd5);

    // Reset during CONV cycle 4
    send(32'h12345678, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_valid_out", {31'd0, valid_out}, 32'd0);
    check("midrst_bin", {4'd0, bin}, 32'd0);
    check("midrst_error", {31'd0, error}, 32'd0);
    sb.delete();
    n_pushed--;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (15) @(posedge clk);   // monitor flags any stray valid_out
    #1;
    send(32'h12345678, 1'b0);
    drain();

    // Randomized operands, occasionally with an invalid digit
    for (int i = 0; i < 40; i++) begin
      logic [31:0] b;
      int          nd;
      b  = 32'd0;
      nd = $urandom_range(1, 8);
      for (int k = 0; k < nd; k++) begin
        b = b | (32'($urandom_range(0, 9)) << (4 * k));
      end
      if ($urandom_range(0, 7) == 0) begin
        int k;
        k = $urandom_range(0, 7);
        b = (b & ~(32'hF << (4 * k))) | (32'($urandom_range(10, 15)) << (4 * k));
      end
      send(b, 1'($urandom_range(0, 1)));
    end
    drain();

    check("result_count", 32'(n_results), 32'(n_pushed));
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
